echo_timer: RTL and testbench

ECHO_TIMER -- requirements
Module: echo_timer

---
 rtl/echo_timer_if.sv | 23 ++
 rtl/echo_timer.sv | 130 +++++++++++++
 tb/tb_echo_timer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_timer_if.sv
// rtl/echo_timer_if.sv - ultrasonic echo timer request/result signal bundle
interface echo_timer_if #(
    parameter int CNT_W = 16
);
    logic             ENABLE;
    logic             ECHO;
    logic             pulse;
    logic [CNT_W-1:0] count;
    logic             calculate;
    logic             busy;
    logic             timeout;
    logic             overflow;

    modport master (
        output ENABLE, ECHO,
        input  pulse, count, calculate, busy, timeout, overflow
    );

    modport slave (
        input  ENABLE, ECHO,
        output pulse, count, calculate, busy, timeout, overflow
    );
endinterface

// File: rtl/echo_timer.sv
// rtl/echo_timer.sv - trigger pulse generator and echo pulse-width measurement FSM
module echo_timer #(
    parameter int CNT_W    = 16,
    parameter int TRIG_CYC = 10,
    parameter int TIMEOUT  = 30000
) (
    input  logic         CLKOUT,
    input  logic         reset,
    echo_timer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE} state_t;

    localparam int TRIG_W = $clog2(TRIG_CYC + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_PEN   = CNT_MAX - CNT_ONE;

    state_t            state;
    state_t            state_nxt;
    logic              echo_m;
    logic              echo_s;
    logic [TRIG_W-1:0] trig_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  count_q;
    logic              pulse_q;
    logic              timeout_q;
    logic              overflow_q;

    // ECHO is asynchronous; only the second flop feeds the FSM
    always_ff @(posedge CLKOUT) begin
        if (reset) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= bus.ECHO;
            echo_s <= echo_m;
        end
    end

    always_ff @(posedge CLKOUT) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.ENABLE) begin
                    state_nxt = TRIG;
                end
            end
            TRIG: begin
                if (trig_cnt == TRIG_LAST) begin
                    state_nxt = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
                if (echo_s) begin
                    state_nxt = (CNT_ONE == CNT_MAX) ? DONE : MEASURE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = DONE;
                end
            end
            MEASURE: begin
                if (!echo_s || count_q == CNT_PEN) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers stay frozen from DONE until the next start request
    always_ff @(posedge CLKOUT) begin
        if (reset) begin
            pulse_q    <= 1'b0;
            trig_cnt   <= '0;
            wait_cnt   <= '0;
            count_q    <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pulse_q  <= (state_nxt == TRIG);
            trig_cnt <= (state == TRIG) ? trig_cnt + 1'b1 : '0;
            wait_cnt <= (state == WAIT_ECHO) ? wait_cnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (bus.ENABLE) begin
                        count_q    <= '0;
                        timeout_q  <= 1'b0;
                        overflow_q <= 1'b0;
                    end
                end
                WAIT_ECHO: begin
                    if (echo_s) begin
                        count_q    <= CNT_ONE;
                        overflow_q <= (CNT_ONE == CNT_MAX);
                    end else if (wait_cnt == WAIT_LAST) begin
                        count_q   <= '0;
                        timeout_q <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (echo_s) begin
                        count_q <= count_q + CNT_ONE;
                        if (count_q == CNT_PEN) begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pulse     = pulse_q;
    assign bus.count     = count_q;
    assign bus.calculate = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.timeout   = timeout_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_echo_timer.sv
// tb/tb_echo_timer.sv - self-checking bench for echo_timer against a timing-rule model
module tb_echo_timer;
    localparam int CNT_W    = 8;
    localparam int TRIG_CYC = 10;
    localparam int TIMEOUT  = 100;
    localparam int CMAX     = 255;

    logic CLKOUT = 1'b0;
    logic reset  = 1'b1;
    int   errors = 0;
    int   checks = 0;

    echo_timer_if #(.CNT_W(CNT_W)) bus ();

    echo_timer #(
        .CNT_W(CNT_W),
        .TRIG_CYC(TRIG_CYC),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLKOUT(CLKOUT),
        .reset(reset),
        .bus(bus)
    );

    always #5 CLKOUT = ~CLKOUT;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        bus.ENABLE = 1'b0;
        bus.ECHO   = 1'b0;
        reset      = 1'b1;
        repeat (3) @(negedge CLKOUT);
        checks++;
        if ({bus.pulse, bus.calculate, bus.busy, bus.timeout, bus.overflow} !== 5'b0 || bus.count !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: pulse=%b calc=%b busy=%b to=%b ov=%b count=%0d, expected all 0",
                     bus.pulse, bus.calculate, bus.busy, bus.timeout, bus.overflow, bus.count);
        end
        reset = 1'b0;
        repeat (5) @(negedge CLKOUT);
        checks++;
        if (bus.busy !== 1'b0 || bus.pulse !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b pulse=%b, expected 0 0", bus.busy, bus.pulse);
        end
    endtask

    // Called on the first negedge where pulse is expected high.
    // Echo driven at step n (counted from the first pulse-low sample) is seen by the
    // FSM two cycles later, i.e. in wait cycle n+2 of the TIMEOUT-cycle window.
    task automatic do_meas(input int d, input int h, input bit extra_en, input string name);
        int  plen;
        int  n;
        int  calc_n;
        bit  seen;
        int  exp_cnt;
        int  exp_n;
        bit  exp_to;
        bit  exp_ov;
        exp_to  = (h == 0) || (d + 2 >= TIMEOUT);
        exp_cnt = exp_to ? 0 : ((h > CMAX) ? CMAX : h);
        exp_ov  = !exp_to && (h >= CMAX);
        exp_n   = exp_to ? TIMEOUT : d + 2 + exp_cnt + ((h < CMAX) ? 1 : 0);

        plen = 0;
        while (bus.pulse === 1'b1 && plen < 50) begin
            plen++;
            if (plen == 1) begin
                checks++;
                if (bus.count !== 8'd0 || bus.timeout !== 1'b0 || bus.overflow !== 1'b0 || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s start_clear: count=%0d to=%b ov=%b busy=%b, expected 0 0 0 1",
                             name, bus.count, bus.timeout, bus.overflow, bus.busy);
                end
            end
            @(negedge CLKOUT);
        end
        checks++;
        if (plen != TRIG_CYC) begin
            errors++;
            $display("FAIL %s pulse_len: got %0d cycles, expected %0d", name, plen, TRIG_CYC);
        end

        n      = 0;
        seen   = 1'b0;
        calc_n = -1;
        while (!seen && n < 600) begin
            if (bus.calculate === 1'b1) begin
                seen   = 1'b1;
                calc_n = n;
            end else begin
                bus.ECHO = (n >= d && n < d + h);
                if (extra_en) bus.ENABLE = (n == d + 4);
                @(negedge CLKOUT);
                n++;
            end
        end
        checks++;
        if (calc_n != exp_n) begin
            errors++;
            $display("FAIL %s calc_time: got %0d cycles after pulse fall, expected %0d", name, calc_n, exp_n);
        end
        checks++;
        if (bus.count !== CNT_W'(exp_cnt) || bus.timeout !== exp_to || bus.overflow !== exp_ov) begin
            errors++;
            $display("FAIL %s result: count=%0d to=%b ov=%b, expected count=%0d to=%b ov=%b",
                     name, bus.count, bus.timeout, bus.overflow, exp_cnt, exp_to, exp_ov);
        end
        checks++;
        if (bus.timeout === 1'b1 && bus.overflow === 1'b1) begin
            errors++;
            $display("FAIL %s flags_exclusive: to=1 ov=1, expected at most one", name);
        end

        bus.ECHO = (n >= d && n < d + h);
        @(negedge CLKOUT);
        n++;
        checks++;
        if (bus.calculate !== 1'b0 || bus.busy !== 1'b0 || bus.pulse !== 1'b0) begin
            errors++;
            $display("FAIL %s after_calc: calc=%b busy=%b pulse=%b, expected 0 0 0",
                     name, bus.calculate, bus.busy, bus.pulse);
        end
        while (n < d + h) begin
            bus.ECHO = 1'b1;
            @(negedge CLKOUT);
            n++;
            checks++;
            if (bus.calculate !== 1'b0 || bus.busy !== 1'b0 || bus.count !== CNT_W'(exp_cnt)) begin
                errors++;
                $display("FAIL %s echo_tail: calc=%b busy=%b count=%0d, expected 0 0 %0d",
                         name, bus.calculate, bus.busy, bus.count, exp_cnt);
            end
        end
        bus.ECHO = 1'b0;
    endtask

    task automatic start_single(input string name);
        bus.ENABLE = 1'b1;
        @(negedge CLKOUT);
        bus.ENABLE = 1'b0;
        checks++;
        if (bus.pulse !== 1'b1) begin
            errors++;
            $display("FAIL %s pulse_rise: pulse=%b, expected 1", name, bus.pulse);
        end
    endtask

    task automatic run_single(input int d, input int h, input bit extra_en, input string name);
        start_single(name);
        do_meas(d, h, extra_en, name);
        repeat (4) @(negedge CLKOUT);
    endtask

    task automatic test_directed();
        run_single(0, 37, 1'b0, "echo37");
        run_single(0, 0, 1'b0, "timeout");
        run_single(0, 300, 1'b0, "overflow");
        run_single(97, 10, 1'b0, "last_wait_cycle");
        run_single(98, 10, 1'b0, "just_too_late");
        run_single(0, 254, 1'b0, "below_max");
        run_single(2, 40, 1'b1, "extra_enable");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int d;
            int h;
            d = $urandom_range(0, 105);
            h = (i == 3) ? 0 : $urandom_range(1, 300);
            run_single(d, h, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid();
        int k;
        start_single("rst_trig");
        repeat (3) @(negedge CLKOUT);
        reset = 1'b1;
        @(negedge CLKOUT);
        reset = 1'b0;
        checks++;
        if (bus.pulse !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_trig: pulse=%b busy=%b, expected 0 0", bus.pulse, bus.busy);
        end
        repeat (15) @(negedge CLKOUT);
        checks++;
        if (bus.pulse !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_trig_restart: pulse=%b busy=%b, expected 0 0", bus.pulse, bus.busy);
        end

        start_single("rst_meas");
        k = 0;
        while (bus.pulse === 1'b1 && k < 50) begin
            @(negedge CLKOUT);
            k++;
        end
        bus.ECHO = 1'b1;
        k = 0;
        while (bus.count !== 8'd20 && k < 100) begin
            @(negedge CLKOUT);
            k++;
        end
        checks++;
        if (bus.count !== 8'd20) begin
            errors++;
            $display("FAIL rst_meas_reach20: count=%0d, expected 20", bus.count);
        end
        reset = 1'b1;
        @(negedge CLKOUT);
        reset = 1'b0;
        checks++;
        if ({bus.pulse, bus.calculate, bus.busy, bus.timeout, bus.overflow} !== 5'b0 || bus.count !== 8'd0) begin
            errors++;
            $display("FAIL rst_meas_outputs: pulse=%b calc=%b busy=%b to=%b ov=%b count=%0d, expected all 0",
                     bus.pulse, bus.calculate, bus.busy, bus.timeout, bus.overflow, bus.count);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge CLKOUT);
            checks++;
            if (bus.calculate !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_meas_quiet: calc=%b busy=%b, expected 0 0", bus.calculate, bus.busy);
            end
        end
        bus.ECHO = 1'b0;
        repeat (4) @(negedge CLKOUT);
    endtask

    task automatic test_back_to_back();
        bus.ENABLE = 1'b1;
        @(negedge CLKOUT);
        for (int i = 0; i < 3; i++) begin
            do_meas(2, 5, 1'b0, "b2b");
            @(negedge CLKOUT);
            checks++;
            if (bus.pulse !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gap: pulse=%b one cycle after idle, expected 1", bus.pulse);
            end
        end
        bus.ENABLE = 1'b0;
        do_meas(1, 5, 1'b0, "b2b_last");
        repeat (4) @(negedge CLKOUT);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: busy=%b, expected 0", bus.busy);
        end
    endtask

    initial begin
        bus.ENABLE = 1'b0;
        bus.ECHO   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
